// File: rtl/br_resolve_ctrl.sv
// ============================================================================
// br_resolve_ctrl : branch resolution arbiter turning resolution requests into
//                   CLEAR / SQUASH tasks for the branch stack.   Revision 1.0
// ============================================================================
`default_nettype none

`ifndef BRANCH_PRED_SZ
`define BRANCH_PRED_SZ 4
`endif
`ifndef N
`define N 2
`endif

module br_resolve_ctrl #(
   parameter int DEPTH          = `BRANCH_PRED_SZ,
   parameter int N              = `N,
   parameter int RECOVER_CYCLES = 2,
   parameter int ADDR_W         = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [N-1:0]                 res_valid,
   input  logic [N-1:0][DEPTH-1:0]      res_b_id,
   input  logic [N-1:0][DEPTH-1:0]      res_b_mask,
   input  logic [N-1:0]                 res_mispredict,
   input  logic [N-1:0][ADDR_W-1:0]     res_target,
   output logic [1:0]                   br_task,
   output logic [DEPTH-1:0]             rem_b_id,
   output logic                         redirect_valid,
   output logic [ADDR_W-1:0]            redirect_pc,
   output logic                         stall_dispatch,
   output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

   localparam logic [1:0] TASK_NOTHING = 2'd0;
   localparam logic [1:0] TASK_CLEAR   = 2'd1;
   localparam logic [1:0] TASK_SQUASH  = 2'd2;
   localparam int CW = $clog2(DEPTH+1);
   localparam int RW = $clog2(RECOVER_CYCLES+2);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SQUASH  = 2'd1,
      S_RECOVER = 2'd2
   } state_t;

   state_t                      state;
   logic [RW-1:0]               cnt;
   logic [DEPTH-1:0]            sq_dep;
   logic [DEPTH-1:0]            pend_v;
   logic [DEPTH-1:0][DEPTH-1:0] pend_mask;

   logic [N-1:0]                live;
   logic [N-1:0]                mis;
   logic [N-1:0]                good;
   logic [N-1:0]                elig;
   logic                        sel_valid;
   logic [DEPTH-1:0]            sel_id;
   logic [ADDR_W-1:0]           sel_pc;
   logic                        clr_valid;
   logic                        issue_clr;
   logic [DEPTH-1:0]            clr_id;
   logic [DEPTH-1:0]            nxt_v;
   logic [DEPTH-1:0][DEPTH-1:0] nxt_mask;
   logic [CW-1:0]               nxt_cnt;

   // Request filtering and oldest-mispredict selection.
   always_comb begin
      live      = '0;
      mis       = '0;
      good      = '0;
      sel_valid = 1'b0;
      sel_id    = '0;
      sel_pc    = '0;
      for (int i = 0; i < N; i++) begin
         live[i] = res_valid[i] && (res_b_id[i] != sq_dep) &&
                   ((res_b_mask[i] & sq_dep) == '0);
         mis[i]  = live[i] && res_mispredict[i];
         good[i] = live[i] && !res_mispredict[i];
      end
      elig = mis;
      for (int j = 0; j < N; j++) begin
         for (int i = 0; i < N; i++) begin
            if (i != j && mis[i] && ((res_b_mask[j] & res_b_id[i]) != '0))
               elig[j] = 1'b0;
         end
      end
      // A circular dependency leaves nobody eligible; fall back to port order.
      if (elig == '0)
         elig = mis;
      for (int j = N-1; j >= 0; j--) begin
         if (elig[j]) begin
            sel_valid = 1'b1;
            sel_id    = res_b_id[j];
            sel_pc    = res_target[j];
         end
      end
   end

   // Pending-table next state: clear issue, new writes, squash drop.
   always_comb begin
      clr_valid = 1'b0;
      clr_id    = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (pend_v[k]) begin
            clr_valid = 1'b1;
            clr_id    = DEPTH'(1) << k;
         end
      end
      issue_clr = clr_valid && !sel_valid;

      nxt_v    = pend_v;
      nxt_mask = pend_mask;
      if (issue_clr)
         nxt_v = nxt_v & ~clr_id;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (good[i] && res_b_id[i][k]) begin
               nxt_v[k]    = 1'b1;
               nxt_mask[k] = res_b_mask[i];
            end
         end
      end
      nxt_cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (issue_clr)
            nxt_mask[k] = nxt_mask[k] & ~clr_id;
         if (sel_valid && (((nxt_mask[k] & sel_id) != '0) || sel_id[k]))
            nxt_v[k] = 1'b0;
         if (!nxt_v[k])
            nxt_mask[k] = '0;
         nxt_cnt = nxt_cnt + CW'(nxt_v[k]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cnt            <= '0;
         sq_dep         <= '0;
         pend_v         <= '0;
         pend_mask      <= '0;
         br_task        <= TASK_NOTHING;
         rem_b_id       <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         stall_dispatch <= 1'b0;
         pend_cnt       <= '0;
      end else begin
         pend_v    <= nxt_v;
         pend_mask <= nxt_mask;
         pend_cnt  <= nxt_cnt;
         if (sel_valid) begin
            state          <= S_SQUASH;
            cnt            <= RW'(RECOVER_CYCLES);
            sq_dep         <= sel_id;
            br_task        <= TASK_SQUASH;
            rem_b_id       <= sel_id;
            redirect_valid <= 1'b1;
            redirect_pc    <= sel_pc;
            stall_dispatch <= 1'b1;
         end else begin
            br_task        <= issue_clr ? TASK_CLEAR : TASK_NOTHING;
            rem_b_id       <= issue_clr ? clr_id : '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            case (state)
               S_IDLE: begin
                  stall_dispatch <= 1'b0;
               end
               S_SQUASH: begin
                  if (RECOVER_CYCLES == 0) begin
                     state          <= S_IDLE;
                     stall_dispatch <= 1'b0;
                  end else begin
                     state          <= S_RECOVER;
                     stall_dispatch <= 1'b1;
                  end
               end
               S_RECOVER: begin
                  if (cnt <= RW'(1)) begin
                     state          <= S_IDLE;
                     cnt            <= '0;
                     stall_dispatch <= 1'b0;
                  end else begin
                     cnt            <= cnt - RW'(1);
                     stall_dispatch <= 1'b1;
                  end
               end
               default: begin
                  state          <= S_IDLE;
                  cnt            <= '0;
                  stall_dispatch <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_br_resolve_ctrl.sv
// ============================================================================
// tb_br_resolve_ctrl : directed scenarios plus randomized traffic checked
//                      against a behavioural model.          Revision 1.0
// ============================================================================
`default_nettype none

module tb_br_resolve_ctrl;

   localparam int DEPTH = 4;
   localparam int N     = 2;
   localparam int RC    = 2;
   localparam int AW    = 32;
   localparam int CW    = $clog2(DEPTH+1);
   localparam logic [1:0] TK_NOTHING = 2'd0;
   localparam logic [1:0] TK_CLEAR   = 2'd1;
   localparam logic [1:0] TK_SQUASH  = 2'd2;

   logic                     clock = 1'b0;
   logic                     reset = 1'b0;
   logic [N-1:0]             res_valid;
   logic [N-1:0][DEPTH-1:0]  res_b_id;
   logic [N-1:0][DEPTH-1:0]  res_b_mask;
   logic [N-1:0]             res_mispredict;
   logic [N-1:0][AW-1:0]     res_target;
   logic [1:0]               br_task;
   logic [DEPTH-1:0]         rem_b_id;
   logic                     redirect_valid;
   logic [AW-1:0]            redirect_pc;
   logic                     stall_dispatch;
   logic [CW-1:0]            pend_cnt;

   always #5 clock = ~clock;

   br_resolve_ctrl #(.DEPTH(DEPTH), .N(N), .RECOVER_CYCLES(RC), .ADDR_W(AW)) dut (
      .clock          (clock),
      .reset          (reset),
      .res_valid      (res_valid),
      .res_b_id       (res_b_id),
      .res_b_mask     (res_b_mask),
      .res_mispredict (res_mispredict),
      .res_target     (res_target),
      .br_task        (br_task),
      .rem_b_id       (rem_b_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_dispatch (stall_dispatch),
      .pend_cnt       (pend_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural model: pending clears keyed by b_id position, stall as a
   // simple countdown of remaining stalled cycles.
   bit               m_v [DEPTH];
   logic [DEPTH-1:0] m_mask [DEPTH];
   logic [DEPTH-1:0] m_sqd;
   int               m_stall;
   logic [1:0]       e_task;
   logic [DEPTH-1:0] e_rem;
   logic             e_rv;
   logic [AW-1:0]    e_pc;
   logic             e_stall;
   int               e_cnt;

   function automatic int oh2i(input logic [DEPTH-1:0] v);
      for (int k = 0; k < DEPTH; k++)
         if (v[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < DEPTH; k++) begin
         m_v[k]    = 1'b0;
         m_mask[k] = '0;
      end
      m_sqd   = '0;
      m_stall = 0;
   endtask

   task automatic model_step();
      logic [N-1:0]     acc;
      logic [N-1:0]     mp;
      logic [DEPTH-1:0] s;
      int               win;
      bit               older;
      bit               cleared;
      int               ck;
      win     = -1;
      cleared = 1'b0;
      ck      = 0;
      s       = '0;
      for (int i = 0; i < N; i++) begin
         acc[i] = res_valid[i] && (res_b_id[i] != m_sqd) && ((res_b_mask[i] & m_sqd) == '0);
         mp[i]  = acc[i] && res_mispredict[i];
      end
      for (int j = 0; j < N; j++) begin
         if (mp[j] && win < 0) begin
            older = 1'b0;
            for (int i = 0; i < N; i++)
               if (i != j && mp[i] && ((res_b_mask[j] & res_b_id[i]) != '0)) older = 1'b1;
            if (!older) win = j;
         end
      end
      if (win < 0)
         for (int j = N-1; j >= 0; j--)
            if (mp[j]) win = j;
      e_task = TK_NOTHING;
      e_rem  = '0;
      e_rv   = 1'b0;
      e_pc   = '0;
      if (win >= 0) begin
         s       = res_b_id[win];
         e_task  = TK_SQUASH;
         e_rem   = s;
         e_rv    = 1'b1;
         e_pc    = res_target[win];
         m_stall = 1 + RC;
         m_sqd   = s;
      end else begin
         if (m_stall > 0) m_stall--;
         for (int k = 0; k < DEPTH; k++) begin
            if (m_v[k] && !cleared) begin
               cleared = 1'b1;
               ck      = k;
               m_v[k]  = 1'b0;
               e_task  = TK_CLEAR;
               e_rem   = DEPTH'(1) << k;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (acc[i] && !mp[i]) begin
            m_v[oh2i(res_b_id[i])]    = 1'b1;
            m_mask[oh2i(res_b_id[i])] = res_b_mask[i];
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (cleared) m_mask[k][ck] = 1'b0;
         if (win >= 0 && m_v[k] && (((m_mask[k] & s) != '0) || s[k])) m_v[k] = 1'b0;
      end
      e_stall = (m_stall > 0);
      e_cnt   = 0;
      for (int k = 0; k < DEPTH; k++) e_cnt += int'(m_v[k]);
   endtask

   task automatic drive(input logic [N-1:0] v,
                        input logic [DEPTH-1:0] id0, input logic [DEPTH-1:0] m0,
                        input logic mp0, input logic [AW-1:0] t0,
                        input logic [DEPTH-1:0] id1, input logic [DEPTH-1:0] m1,
                        input logic mp1, input logic [AW-1:0] t1);
      res_valid      = v;
      res_b_id[0]    = id0;  res_b_mask[0] = m0;  res_mispredict[0] = mp0;  res_target[0] = t0;
      res_b_id[1]    = id1;  res_b_mask[1] = m1;  res_mispredict[1] = mp1;  res_target[1] = t1;
   endtask

   task automatic idle();
      drive(2'b00, '0, '0, 1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".task"},  64'(br_task),        64'(TK_NOTHING));
      check({tag, ".rem"},   64'(rem_b_id),       64'(0));
      check({tag, ".rv"},    64'(redirect_valid), 64'(0));
      check({tag, ".pc"},    64'(redirect_pc),    64'(0));
      check({tag, ".stall"}, 64'(stall_dispatch), 64'(0));
      check({tag, ".cnt"},   64'(pend_cnt),       64'(0));
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clock);
      #1;
      check({tag, ".task"},  64'(br_task),        64'(e_task));
      check({tag, ".rem"},   64'(rem_b_id),       64'(e_rem));
      check({tag, ".rv"},    64'(redirect_valid), 64'(e_rv));
      check({tag, ".pc"},    64'(redirect_pc),    64'(e_pc));
      check({tag, ".stall"}, 64'(stall_dispatch), 64'(e_stall));
      check({tag, ".cnt"},   64'(pend_cnt),       64'(e_cnt));
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      @(posedge clock);
      #1;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check_zero("reset");
      @(negedge clock);
      reset = 1'b1;
      step("post_reset");

      // Single correct resolution becomes a CLEAR once pending.
      drive(2'b01, 4'b0001, 4'b0000, 1'b0, 32'h0, '0, '0, 1'b0, '0);
      step("s23a");
      check("s23_pending", 64'(pend_cnt), 64'(1));
      step("s23b");
      check("s23_clear", 64'(br_task), 64'(TK_CLEAR));
      check("s23_rem", 64'(rem_b_id), 64'(4'b0001));
      check("s23_cnt0", 64'(pend_cnt), 64'(0));

      // Two mispredicts: port1 is older and wins.
      drive(2'b11, 4'b0100, 4'b0011, 1'b1, 32'hA000_0000,
                   4'b0010, 4'b0001, 1'b1, 32'hB000_0000);
      step("s24_sq");
      check("s24_task", 64'(br_task), 64'(TK_SQUASH));
      check("s24_rem", 64'(rem_b_id), 64'(4'b0010));
      check("s24_pc", 64'(redirect_pc), 64'(32'hB000_0000));
      step("s24_r1");
      check("s24_stall2", 64'(stall_dispatch), 64'(1));
      check("s24_rv_low", 64'(redirect_valid), 64'(0));
      step("s24_r2");
      check("s24_stall3", 64'(stall_dispatch), 64'(1));
      step("s24_done");
      check("s24_stall_end", 64'(stall_dispatch), 64'(0));
      step("s24_quiet");

      // Squash drops the dependent pending entry; older CLEAR issues in RECOVER.
      do_reset();
      drive(2'b11, 4'b0001, 4'b0000, 1'b0, '0, 4'b0100, 4'b0010, 1'b0, '0);
      step("s25_wr");
      check("s25_two", 64'(pend_cnt), 64'(2));
      drive(2'b01, 4'b0010, 4'b0000, 1'b1, 32'hC0DE_0010, '0, '0, 1'b0, '0);
      step("s25_sq");
      check("s25_sqtask", 64'(br_task), 64'(TK_SQUASH));
      check("s25_one", 64'(pend_cnt), 64'(1));
      step("s25_clr");
      check("s25_clrtask", 64'(br_task), 64'(TK_CLEAR));
      check("s25_clrid", 64'(rem_b_id), 64'(4'b0001));
      check("s25_in_recover", 64'(stall_dispatch), 64'(1));
      repeat (3) step("s25_tail");

      // Nested mispredict during RECOVER restarts the stall window.
      do_reset();
      drive(2'b01, 4'b0100, 4'b0001, 1'b1, 32'h0000_0400, '0, '0, 1'b0, '0);
      step("s26_sq1");
      step("s26_r1");
      drive(2'b01, 4'b0001, 4'b0000, 1'b1, 32'h0000_0100, '0, '0, 1'b0, '0);
      step("s26_sq2");
      check("s26_rem2", 64'(rem_b_id), 64'(4'b0001));
      check("s26_pc2", 64'(redirect_pc), 64'(32'h0000_0100));
      step("s26_a");
      check("s26_stall_a", 64'(stall_dispatch), 64'(1));
      step("s26_b");
      check("s26_stall_b", 64'(stall_dispatch), 64'(1));
      step("s26_c");
      check("s26_stall_c", 64'(stall_dispatch), 64'(0));

      // Request dependent on the squashed branch is ignored.
      do_reset();
      drive(2'b01, 4'b0010, 4'b0000, 1'b1, 32'h0000_0020, '0, '0, 1'b0, '0);
      step("s27_sq");
      drive(2'b01, 4'b1000, 4'b0010, 1'b0, '0, '0, '0, 1'b0, '0);
      step("s27_ign");
      check("s27_cnt", 64'(pend_cnt), 64'(0));
      step("s27_noclr");
      check("s27_task", 64'(br_task), 64'(TK_NOTHING));

      // Asynchronous reset in RECOVER with two entries pending.
      do_reset();
      drive(2'b11, 4'b1000, 4'b0000, 1'b1, 32'h0000_8000, 4'b0001, 4'b0000, 1'b0, '0);
      step("s28_sq");
      drive(2'b11, 4'b0010, 4'b0000, 1'b0, '0, 4'b0100, 4'b0000, 1'b0, '0);
      step("s28_rec");
      check("s28_two", 64'(pend_cnt), 64'(2));
      check("s28_stall", 64'(stall_dispatch), 64'(1));
      #2;
      reset = 1'b0;
      #1;
      check_zero("s28_async");
      @(posedge clock);
      #1;
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      step("s28_after");

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0]     v;
         logic [DEPTH-1:0] id [N];
         logic [DEPTH-1:0] mk [N];
         logic [N-1:0]     mp;
         logic [AW-1:0]    tg [N];
         for (int p = 0; p < N; p++) begin
            v[p]  = 1'($urandom_range(0, 1));
            id[p] = DEPTH'(1) << $urandom_range(0, DEPTH-1);
            mk[p] = DEPTH'($urandom) & ~id[p];
            mp[p] = ($urandom_range(0, 4) == 0);
            tg[p] = AW'($urandom);
         end
         drive(v, id[0], mk[0], mp[0], tg[0], id[1], mk[1], mp[1], tg[1]);
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/br_resolve_ctrl.md
BR_RESOLVE_CTRL -- requirements
Module: br_resolve_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default `BRANCH_PRED_SZ, meaning the number of branch-stack checkpoints and the one-hot BR_MASK width.
REQ-002 SHALL have parameter N, default `N, meaning the number of branch-resolution ports.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 2, meaning the number of dispatch-stall cycles following a SQUASH.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports are named clock and reset.
REQ-005 SHALL have ports, in this order:
- clock  in  1  system clock.
- reset  in  1  async active-low reset.
- res_valid  in  [N]  resolution request per port.
- res_b_id  in  BR_MASK[N]  one-hot b_id of the resolving branch.
- res_b_mask  in  BR_MASK[N]  b_ids of older unresolved branches the resolving branch depends on.
- res_mispredict  in  [N]  1 means squash required; 0 means correctly predicted.
- res_target  in  ADDR[N]  correct next PC.
- br_task  out  BR_TASK  NOTHING, CLEAR or SQUASH to the branch stack; registered.
- rem_b_id  out  BR_MASK  b_id operated on by br_task; registered.
- redirect_valid  out  1  fetch redirect; high in the SQUASH cycle only.
- redirect_pc  out  ADDR  redirect target.
- stall_dispatch  out  1  dispatch stall.
- pend_cnt  out  $clog2(DEPTH+1)  number of pending clears.

Function
REQ-006 SHALL hold a pending-clear table indexed by b_id bit position: pend_v[DEPTH] and pend_mask[DEPTH][DEPTH], the latter holding the dependency mask of each entry.
REQ-007 SHALL define ordering as follows: request i is older than request j iff res_b_mask[j] & res_b_id[i] != 0.
REQ-008 SHALL select, each cycle, the oldest valid, non-ignored mispredicting request; on a tie or duplicate b_id, the lowest port index wins.
REQ-009 SHALL register a selected mispredict for output in the next cycle: br_task=SQUASH, rem_b_id=its b_id, redirect_valid=1, redirect_pc=its res_target.
REQ-010 SHALL write each valid, non-ignored, correctly predicted request into the pending table (pend_v=1, pend_mask=res_b_mask) in the cycle it is received.
REQ-011 SHALL, in a cycle with no SQUASH to issue, issue the lowest-index valid pending entry as br_task=CLEAR with rem_b_id set to that entry's one-hot b_id, and invalidate that entry at the clock edge; otherwise br_task=NOTHING and rem_b_id=0.
REQ-012 SHALL, when a CLEAR of bit k issues, clear bit k in the pend_mask of every pending entry.
REQ-013 SHALL give SQUASH priority over CLEAR; any CLEAR preempted this way remains pending.
REQ-014 SHALL, when a SQUASH of b_id s is registered, drop every pending entry with pend_mask & s != 0 and every entry equal to s, in the same cycle.
REQ-015 SHALL latch s as sq_dep; until the next SQUASH or reset, it ignores any request with res_b_id == sq_dep or with res_b_mask & sq_dep != 0.
REQ-016 SHALL implement the FSM IDLE -> SQUASH -> RECOVER -> IDLE:
- SQUASH lasts 1 cycle.
- RECOVER lasts RECOVER_CYCLES cycles, counted by a down-counter.
- stall_dispatch=1 in SQUASH and RECOVER.
REQ-017 SHALL allow CLEARs of pending entries (necessarily older) to issue during RECOVER.
REQ-018 SHALL, on a new accepted mispredict in SQUASH or RECOVER, re-enter SQUASH, replace sq_dep, and reload the counter.
REQ-019 SHALL drive pend_cnt as the popcount of pend_v after the current cycle's updates are registered.
REQ-020 SHALL NOT overflow the pending table: at most one entry exists per b_id, and a rewrite of a valid entry overwrites it.

Reset
REQ-021 SHALL, on reset low, asynchronously force:
- FSM=IDLE and counter=0.
- pend_v=0, pend_mask=0, sq_dep=0.
- br_task=NOTHING, rem_b_id=0.
- redirect_valid=0, redirect_pc=0.
- stall_dispatch=0, pend_cnt=0.
REQ-022 SHALL discard an in-flight squash or recover on mid-operation reset, and SHALL emit no CLEAR or SQUASH in the first cycle after reset deasserts unless a request is presented in that cycle.

Verification (DEPTH=4, N=2, RECOVER_CYCLES=2)
REQ-023 SHALL be covered by the scenario: port0 correct b_id=0001, mask=0000 -> next cycle CLEAR, rem_b_id=0001; pend_cnt returns to 0.
REQ-024 SHALL be covered by the scenario: in one cycle, port0 mispredict b_id=0100 mask=0011 and port1 mispredict b_id=0010 mask=0001 -> SQUASH rem_b_id=0010 with port1's target; stall_dispatch high for 3 cycles; port0's request never issues.
REQ-025 SHALL be covered by the scenario: pending clears 0001 (mask 0000) and 0100 (mask 0010), then mispredict 0010 -> SQUASH 0010; entry 0100 dropped; CLEAR 0001 issues in RECOVER.
REQ-026 SHALL be covered by the scenario: mispredict 0100 (mask 0001), then during RECOVER mispredict 0001 -> second SQUASH 0001; counter reloaded; stall lasts 3 cycles from the second SQUASH.
REQ-027 SHALL be covered by the scenario: after SQUASH 0010, port0 correct b_id=1000 mask=0010 -> ignored, no CLEAR, pend_cnt=0.
REQ-028 SHALL be covered by the scenario: reset asserted during RECOVER with 2 pending clears -> all outputs 0 immediately, with no clock edge required.
